// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl
// Pipeline-side initiator for the HI/LO multiply/divide unit. Accepts
// mult/multu/div/divu and mthi/mtlo requests from the E stage, drives the
// unit's start/op/D1/D2/flush inputs, tracks the unit's Busy handshake,
// stalls the pipeline on HI/LO hazards and returns HI/LO for mfhi/mflo.
// Divides by zero are suppressed (reported on div_zero), and a watchdog
// aborts an operation whose Busy never falls.
//
// Handshake: the unit samples md_start/md_op/md_d1/md_d2 at the rising edge
// of the cycle in which they are driven. md_start is a single-cycle strobe.
// The unit answers with md_busy=1 from the next cycle until its result is in
// HI/LO. A move-to is md_op=101/110 with md_start=0 and is written at that
// same edge.
//
// Ports:
//   clk, reset (async, active-low)     clock / reset
//   flush                              pipeline exception flush
//   req_valid, req_op, req_rs, req_rt  E-stage request
//   rd_hi, rd_lo                       E-stage mfhi / mflo
//   md_busy, md_hi, md_lo              from the unit
//   md_start, md_op, md_d1, md_d2      to the unit
//   md_flush                           abort to the unit
//   stall                              freeze F/D/E
//   rdata                              mfhi/mflo result (valid when !stall)
//   div_zero                           1-cycle pulse on a suppressed divide
//   err                                sticky protocol/watchdog error
//   last_lat                           busy RUN cycles of last completed op
//   dbg_state                          FSM state (0 IDLE, 1 ISSUED, 2 RUN)
module md_issue_ctrl #(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_rs,
    input  logic [31:0]      req_rt,
    input  logic             rd_hi,
    input  logic             rd_lo,
    input  logic             md_busy,
    input  logic [31:0]      md_hi,
    input  logic [31:0]      md_lo,
    output logic             md_start,
    output logic [2:0]       md_op,
    output logic [31:0]      md_d1,
    output logic [31:0]      md_d2,
    output logic             md_flush,
    output logic             stall,
    output logic [31:0]      rdata,
    output logic             div_zero,
    output logic             err,
    output logic [CNT_W-1:0] last_lat,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUED = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic             div_zero_q;
    logic             err_set;
    logic             lat_load;

    logic md_req, div0, mv_req, unit_free, issue, mv_go, watchdog;

    // Request decode. A divide by zero never reaches the unit: it retires
    // immediately without stalling, leaving HI/LO untouched.
    always_comb begin
        md_req    = req_valid && (req_op >= OP_MULTU) && (req_op <= OP_DIV);
        div0      = md_req && ((req_op == OP_DIVU) || (req_op == OP_DIV))
                    && (req_rt == 32'd0);
        mv_req    = req_valid && ((req_op == OP_MTHI) || (req_op == OP_MTLO));
        unit_free = (state == S_IDLE) && !md_busy;
        // reset gating keeps every request-driven output at 0 while reset
        // is held, independent of the clock.
        issue     = reset && md_req && unit_free && !flush && !div0;
        mv_go     = reset && mv_req && unit_free && !flush;
        watchdog  = (state == S_RUN) && md_busy && (cnt == CNT_LAST) && !flush;
    end

    // Next state
    always_comb begin
        state_d  = state;
        err_set  = 1'b0;
        lat_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue) state_d = S_ISSUED;
            end
            S_ISSUED: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                    // The unit must raise Busy the cycle after a start.
                    if (!md_busy) err_set = 1'b1;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!md_busy) begin
                    state_d  = S_IDLE;
                    lat_load = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_d = S_IDLE;
                    err_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        md_start  = issue;
        md_op     = (issue || mv_go) ? req_op : OP_NONE;
        md_d1     = (issue || mv_go) ? req_rs : 32'd0;
        md_d2     = issue ? req_rt : 32'd0;
        md_flush  = !reset || flush || watchdog;
        stall     = reset && ((md_req && !div0) || mv_req || rd_hi || rd_lo)
                    && ((state != S_IDLE) || md_busy) && !flush;
        if (!reset)     rdata = 32'd0;
        else if (rd_hi) rdata = md_hi;
        else if (rd_lo) rdata = md_lo;
        else            rdata = 32'd0;
        div_zero  = div_zero_q;
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_lat   <= '0;
            err        <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state      <= state_d;
            div_zero_q <= div0 && !flush;
            if (err_set) err <= 1'b1;
            if (lat_load) last_lat <= cnt;
            // cnt counts RUN cycles with Busy still high; it rests at 0
            // whenever the FSM is not going to be in RUN.
            if (state_d != S_RUN) begin
                cnt <= '0;
            end else if ((state == S_RUN) && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush, req_valid, rd_hi, rd_lo;
    logic [2:0]  req_op;
    logic [31:0] req_rs, req_rt;
    logic        md_busy;
    logic [31:0] md_hi, md_lo;
    logic        md_start, md_flush, stall, div_zero, err;
    logic [2:0]  md_op;
    logic [31:0] md_d1, md_d2, rdata;
    logic [7:0]  last_lat;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL tb_timeout: simulation did not finish");
        $fatal(1);
    end

    md_issue_ctrl #(.TIMEOUT(32), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
        .rd_hi(rd_hi), .rd_lo(rd_lo), .md_busy(md_busy),
        .md_hi(md_hi), .md_lo(md_lo), .md_start(md_start), .md_op(md_op),
        .md_d1(md_d1), .md_d2(md_d2), .md_flush(md_flush), .stall(stall),
        .rdata(rdata), .div_zero(div_zero), .err(err),
        .last_lat(last_lat), .dbg_state(dbg_state)
    );

    // ---------------- mult/div unit model ----------------
    // Busy rises the cycle after start and stays high for the ISSUED cycle
    // plus lat_cfg RUN cycles; HI/LO are written as Busy falls.
    int          busy_cnt = 0;
    int          lat_cfg = 5;
    bit          hang_mode = 1'b0;
    bit          nobusy_mode = 1'b0;
    logic [31:0] u_hi = 32'd0, u_lo = 32'd0, pend_hi = 32'd0, pend_lo = 32'd0;

    assign md_busy = (busy_cnt != 0);
    assign md_hi   = u_hi;
    assign md_lo   = u_lo;

    function automatic logic [63:0] unit_result(input logic [2:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0] r;
        r = 64'd0;
        case (op)
            3'b001: r = {32'd0, a} * {32'd0, b};
            3'b010: r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            3'b011: if (b != 0) r = {a % b, a / b};
            3'b100: if (b != 0) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_cnt <= 0;
        end else if (md_flush) begin
            busy_cnt <= 0;
        end else if (md_start) begin
            if (nobusy_mode) begin
                {u_hi, u_lo} <= unit_result(md_op, md_d1, md_d2);
            end else begin
                {pend_hi, pend_lo} <= unit_result(md_op, md_d1, md_d2);
                busy_cnt <= hang_mode ? 100000 : lat_cfg + 1;
            end
        end else begin
            if (busy_cnt == 1) begin
                u_hi <= pend_hi;
                u_lo <= pend_lo;
            end
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (md_op == 3'b101) u_hi <= md_d1;
            else if (md_op == 3'b110) u_lo <= md_d1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_req();
        flush = 1'b0; req_valid = 1'b0; req_op = 3'b000;
        req_rs = 32'd0; req_rt = 32'd0; rd_hi = 1'b0; rd_lo = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [31:0] rs,
                             input logic [31:0] rt);
        req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_req();
        drive_req(3'b010, 32'd3, 32'd4);
        rd_hi = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (md_flush !== 1'b1) begin failures++; $display("FAIL rst_md_flush: got %b want 1", md_flush); end
        checks++; if (md_start !== 1'b0) begin failures++; $display("FAIL rst_md_start: got %b want 0", md_start); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b want 0", stall); end
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        checks++; if (err !== 1'b0 || last_lat !== 8'd0 || div_zero !== 1'b0) begin failures++; $display("FAIL rst_regs: err=%b last_lat=%0d div_zero=%b want 0", err, last_lat, div_zero); end
        @(negedge clk);
        clear_req();
        reset = 1'b1;
        #1;
        checks++; if (md_flush !== 1'b0 || dbg_state !== 2'd0) begin failures++; $display("FAIL rst_release: md_flush=%b state=%0d want 0/0", md_flush, dbg_state); end
    endtask

    task automatic test_mult();
        int n, starts;
        lat_cfg = 5;
        @(negedge clk);
        drive_req(3'b010, 32'hFFFF_FFFF, 32'd2);
        #1;
        checks++; if (md_start !== 1'b1 || md_op !== 3'b010) begin failures++; $display("FAIL mult_issue: start=%b op=%b want 1/010", md_start, md_op); end
        checks++; if (md_d1 !== 32'hFFFF_FFFF || md_d2 !== 32'd2 || stall !== 1'b0) begin failures++; $display("FAIL mult_operands: d1=%h d2=%h stall=%b", md_d1, md_d2, stall); end
        @(negedge clk);
        clear_req();
        rd_lo = 1'b1;
        #1;
        n = 0; starts = 0;
        while (stall === 1'b1 && n < 50) begin
            if (md_start !== 1'b0) starts++;
            @(negedge clk); #1; n++;
        end
        checks++; if (n !== 7) begin failures++; $display("FAIL mult_mflo_stall: stalled %0d cycles want 7", n); end
        checks++; if (starts !== 0) begin failures++; $display("FAIL mult_single_start: extra starts %0d want 0", starts); end
        checks++; if (rdata !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mult_mflo: got %h want fffffffe", rdata); end
        checks++; if (last_lat !== 8'd5) begin failures++; $display("FAIL mult_last_lat: got %0d want 5", last_lat); end
        @(negedge clk);
        rd_lo = 1'b0; rd_hi = 1'b1;
        #1;
        checks++; if (rdata !== 32'hFFFF_FFFF || stall !== 1'b0) begin failures++; $display("FAIL mult_mfhi: got %h stall=%b want ffffffff/0", rdata, stall); end
    endtask

    task automatic test_div_zero();
        @(negedge clk);
        clear_req();
        drive_req(3'b101, 32'h1234_5678, 32'd0);
        #1;
        checks++; if (md_op !== 3'b101 || md_d1 !== 32'h1234_5678 || md_start !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL mthi_drive: op=%b d1=%h start=%b stall=%b", md_op, md_d1, md_start, stall); end
        @(negedge clk);
        drive_req(3'b100, 32'd7, 32'd0);
        #1;
        checks++; if (md_start !== 1'b0 || md_op !== 3'b000 || stall !== 1'b0) begin failures++; $display("FAIL div0_suppress: start=%b op=%b stall=%b want 0/000/0", md_start, md_op, stall); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL div0_early: got %b want 0", div_zero); end
        @(negedge clk);
        clear_req();
        #1;
        checks++; if (div_zero !== 1'b1 || dbg_state !== 2'd0) begin failures++; $display("FAIL div0_pulse: div_zero=%b state=%0d want 1/0", div_zero, dbg_state); end
        @(negedge clk);
        rd_hi = 1'b1;
        #1;
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL div0_one_cycle: got %b want 0", div_zero); end
        checks++; if (rdata !== 32'h1234_5678 || stall !== 1'b0) begin failures++; $display("FAIL div0_hi_kept: got %h stall=%b want 12345678/0", rdata, stall); end
    endtask

    task automatic test_move_stall();
        int n, bad_ops;
        lat_cfg = 3;
        @(negedge clk);
        clear_req();
        drive_req(3'b011, 32'd100, 32'd7);
        #1;
        checks++; if (md_start !== 1'b1 || md_op !== 3'b011) begin failures++; $display("FAIL divu_issue: start=%b op=%b", md_start, md_op); end
        @(negedge clk);
        clear_req();
        drive_req(3'b110, 32'h0000_AAAA, 32'd0);
        #1;
        n = 0; bad_ops = 0;
        while (stall === 1'b1 && n < 50) begin
            if (md_op !== 3'b000) bad_ops++;
            @(negedge clk); #1; n++;
        end
        checks++; if (n !== 5 || bad_ops !== 0) begin failures++; $display("FAIL mtlo_stall: stalled %0d want 5, early ops %0d want 0", n, bad_ops); end
        checks++; if (md_op !== 3'b110 || md_d1 !== 32'h0000_AAAA || md_start !== 1'b0) begin failures++; $display("FAIL mtlo_drive: op=%b d1=%h start=%b", md_op, md_d1, md_start); end
        @(negedge clk);
        clear_req();
        rd_lo = 1'b1;
        #1;
        checks++; if (rdata !== 32'h0000_AAAA) begin failures++; $display("FAIL mtlo_lo: got %h want 0000aaaa", rdata); end
        @(negedge clk);
        rd_lo = 1'b0; rd_hi = 1'b1;
        #1;
        checks++; if (rdata !== 32'd2 || last_lat !== 8'd3) begin failures++; $display("FAIL divu_hi: hi=%h last_lat=%0d want 2/3", rdata, last_lat); end
    endtask

    task automatic test_flush();
        lat_cfg = 10;
        @(negedge clk);
        clear_req();
        drive_req(3'b010, 32'd3, 32'd4);
        #1;
        checks++; if (md_start !== 1'b1) begin failures++; $display("FAIL flush_issue: start=%b want 1", md_start); end
        @(negedge clk);
        clear_req();
        rd_lo = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (stall !== 1'b1 || md_flush !== 1'b0 || dbg_state !== 2'd2) begin failures++; $display("FAIL flush_run1: stall=%b md_flush=%b state=%0d want 1/0/2", stall, md_flush, dbg_state); end
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (md_flush !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL flush_cycle: md_flush=%b stall=%b want 1/0", md_flush, stall); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (md_flush !== 1'b0 || dbg_state !== 2'd0 || stall !== 1'b0) begin failures++; $display("FAIL flush_after: md_flush=%b state=%0d stall=%b want 0/0/0", md_flush, dbg_state, stall); end
        checks++; if (rdata !== 32'h0000_AAAA || last_lat !== 8'd3) begin failures++; $display("FAIL flush_kept: lo=%h last_lat=%0d want 0000aaaa/3", rdata, last_lat); end
        @(negedge clk);
        rd_lo = 1'b0; rd_hi = 1'b1;
        #1;
        checks++; if (rdata !== 32'd2) begin failures++; $display("FAIL flush_hi_kept: got %h want 2", rdata); end
    endtask

    task automatic test_watchdog();
        int n;
        hang_mode = 1'b1;
        @(negedge clk);
        clear_req();
        drive_req(3'b001, 32'd1, 32'd1);
        #1;
        checks++; if (md_start !== 1'b1) begin failures++; $display("FAIL wd_issue: start=%b want 1", md_start); end
        @(negedge clk);
        clear_req();
        #1;
        n = 1;
        while (md_flush !== 1'b1 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        checks++; if (n !== 33) begin failures++; $display("FAIL wd_fire_cycle: fired after %0d cycles want 33", n); end
        checks++; if (err !== 1'b0 || dbg_state !== 2'd2) begin failures++; $display("FAIL wd_fire_state: err=%b state=%0d want 0/2", err, dbg_state); end
        @(negedge clk);
        #1;
        checks++; if (err !== 1'b1 || dbg_state !== 2'd0 || md_flush !== 1'b0) begin failures++; $display("FAIL wd_after: err=%b state=%0d md_flush=%b want 1/0/0", err, dbg_state, md_flush); end
        checks++; if (last_lat !== 8'd3) begin failures++; $display("FAIL wd_last_lat: got %0d want 3", last_lat); end
        hang_mode = 1'b0;
    endtask

    task automatic test_async_reset();
        lat_cfg = 10;
        @(negedge clk);
        clear_req();
        drive_req(3'b010, 32'd5, 32'd6);
        #1;
        checks++; if (md_start !== 1'b1) begin failures++; $display("FAIL ares_issue: start=%b want 1", md_start); end
        @(negedge clk);
        clear_req();
        rd_hi = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dbg_state !== 2'd2 || stall !== 1'b1) begin failures++; $display("FAIL ares_run: state=%0d stall=%b want 2/1", dbg_state, stall); end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++; if (md_flush !== 1'b1 || dbg_state !== 2'd0 || stall !== 1'b0 || rdata !== 32'd0) begin failures++; $display("FAIL ares_immediate: md_flush=%b state=%0d stall=%b rdata=%h", md_flush, dbg_state, stall, rdata); end
        checks++; if (err !== 1'b0 || last_lat !== 8'd0) begin failures++; $display("FAIL ares_regs: err=%b last_lat=%0d want 0/0", err, last_lat); end
        @(negedge clk);
        #1;
        checks++; if (md_flush !== 1'b1) begin failures++; $display("FAIL ares_held: md_flush=%b want 1", md_flush); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (md_flush !== 1'b0 || dbg_state !== 2'd0 || err !== 1'b0 || last_lat !== 8'd0) begin failures++; $display("FAIL ares_release: md_flush=%b state=%0d err=%b last_lat=%0d", md_flush, dbg_state, err, last_lat); end
        checks++; if (stall !== 1'b0 || rdata !== 32'd2) begin failures++; $display("FAIL ares_hi: stall=%b rdata=%h want 0/2", stall, rdata); end
    endtask

    task automatic test_no_busy();
        nobusy_mode = 1'b1;
        @(negedge clk);
        clear_req();
        drive_req(3'b001, 32'h10, 32'h10);
        #1;
        checks++; if (md_start !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL nobusy_issue: start=%b err=%b want 1/0", md_start, err); end
        @(negedge clk);
        clear_req();
        #1;
        checks++; if (dbg_state !== 2'd1 || err !== 1'b0) begin failures++; $display("FAIL nobusy_issued: state=%0d err=%b want 1/0", dbg_state, err); end
        @(negedge clk);
        #1;
        checks++; if (err !== 1'b1 || dbg_state !== 2'd2) begin failures++; $display("FAIL nobusy_err: err=%b state=%0d want 1/2", err, dbg_state); end
        @(negedge clk);
        rd_lo = 1'b1;
        #1;
        checks++; if (dbg_state !== 2'd0 || last_lat !== 8'd0 || rdata !== 32'h100 || stall !== 1'b0) begin failures++; $display("FAIL nobusy_done: state=%0d last_lat=%0d rdata=%h stall=%b", dbg_state, last_lat, rdata, stall); end
        @(negedge clk);
        clear_req();
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b want 1", err); end
        nobusy_mode = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        clear_req();
        test_reset();
        test_mult();
        test_div_zero();
        test_move_stall();
        test_flush();
        test_watchdog();
        test_async_reset();
        test_no_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
Pipeline-side initiator for the HI/LO multiply/divide unit. It accepts multiply, divide, move-to and move-from requests from the E stage, and drives the unit's start/op/D1/D2/flush inputs. It tracks the unit's Busy handshake, stalls the pipeline on HI/LO hazards and returns HI/LO data for mfhi/mflo. It also enforces divide-by-zero suppression and a busy watchdog.

Parameters:
TIMEOUT, 32, maximum cycles allowed in RUN before the watchdog fires (must be ≥12)
CNT_W, 8, width of the latency counter and last_lat output

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  exception flush from the pipeline
req_valid  in  1  E-stage instruction is valid
req_op  in  3  001 multu, 010 mult, 011 divu, 100 div, 101 mthi, 110 mtlo, 000 none
req_rs  in  32  rs operand
req_rt  in  32  rt operand
rd_hi  in  1  E-stage mfhi
rd_lo  in  1  E-stage mflo
md_busy  in  1  Busy from the unit
md_hi  in  32  HI from the unit
md_lo  in  32  LO from the unit
md_start  out  1  start to the unit
md_op  out  3  mult_div_op to the unit
md_d1  out  32  D1 to the unit
md_d2  out  32  D2 to the unit
md_flush  out  1  flush to the unit
stall  out  1  freeze the F/D/E stages
rdata  out  32  mfhi/mflo result
div_zero  out  1  one-cycle pulse when a divide is suppressed
err  out  1  sticky protocol/watchdog error
last_lat  out  CNT_W  RUN cycles of the last completed operation

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE, cnt 0, last_lat 0, err 0.
  - All outputs are 0, except md_flush, which is 1 while reset is held.
- States and transitions:
  - IDLE to ISSUED on issue.
  - ISSUED to RUN unconditionally. If md_busy=0 in ISSUED, set err.
  - RUN to IDLE when md_busy=0, with last_lat<=cnt.
  - RUN to IDLE when cnt==TIMEOUT-1 and md_busy=1 (watchdog). md_flush=1 that cycle and err set.
- md-class request: req_valid=1 and req_op in 001..100.
- Issue condition (combinational): md-class request & state==IDLE & !md_busy & !flush & !div0.
  - On issue: md_start=1, md_op=req_op, md_d1=req_rs, md_d2=req_rt, all in the same cycle. The unit samples them at that edge.
- div0: req_op in {011,100} & req_rt==0.
  - No start, md_op=000, HI/LO left unchanged.
  - div_zero pulses 1 cycle (registered, so it is visible the cycle after the request).
  - The instruction retires; no stall.
- mthi/mtlo:
  - When state==IDLE & !md_busy & !flush: drive md_op=101/110, md_d1=req_rs, md_start=0. The unit writes at the edge.
  - Otherwise stall.
- md_op=000 whenever there is no issue and no move-to.
- stall=1 when (md-class request | mthi/mtlo | rd_hi | rd_lo) & (state!=IDLE | md_busy) & !flush.
  - A request that issues is never stalled in its own cycle.
- rdata=md_hi when rd_hi, md_lo when rd_lo, otherwise 0. It is combinational and valid only when stall=0. If rd_hi and rd_lo are both set, rd_hi wins.
- cnt: cleared in IDLE, increments each RUN cycle, saturates at all-ones.
- flush:
  - In ISSUED or RUN: md_flush=1 for that cycle, state goes to IDLE, cnt cleared, last_lat unchanged.
  - In IDLE: md_flush=1, no issue, no move-to.
  - flush overrides a simultaneous new request.
- Simultaneous issue and completion is impossible: issue requires IDLE.
- err clears only on reset.

Test Plan:
1. mult, rs=0xFFFFFFFF, rt=2; unit Busy for 5 cycles. Check:
   - md_start=1 for exactly 1 cycle, md_op=010.
   - A following mflo is stalled until md_busy falls.
   - mflo then returns rdata=0xFFFFFFFE; mfhi returns 0xFFFFFFFF.
   - last_lat=5.
2. div, rs=7, rt=0. Check:
   - md_start=0, div_zero pulses 1 cycle, stall=0.
   - A subsequent mfhi returns the prior HI value, e.g. 0x12345678 after mthi 0x12345678.
3. divu, rs=100, rt=7, then mtlo 0xAAAA issued while busy. Check:
   - mtlo is stalled until IDLE, then md_op=110 with md_d1=0xAAAA.
   - Final LO=0xAAAA, HI=2.
4. mult issued, flush asserted in the 2nd RUN cycle. Check:
   - md_flush=1 for 1 cycle, state IDLE, stall drops the same cycle.
   - HI/LO unchanged, last_lat unchanged.
5. Unit model holds md_busy=1 permanently after a start. Check:
   - After TIMEOUT=32 RUN cycles, md_flush pulses, err=1, state IDLE.
   - A second case where md_busy stays 0 in ISSUED also sets err.
6. reset=0 driven asynchronously mid-RUN. Check:
   - Outputs clear immediately without waiting for a clock edge.
   - md_flush=1 during reset; after release, state IDLE, err=0, last_lat=0.
